// File: rtl/ark_share_sequencer_if.sv
// Handshake and read/write-strobe bundle between the masked AddRoundKey
// sequencer and its share register files.
interface ark_share_sequencer_if #(
  parameter int SHARE_W = 2,
  parameter int BYTE_W  = 4
);
  logic               start_i;
  logic               hold_i;
  logic               abort_i;
  logic               busy_o;
  logic               done_o;
  logic               rd_en_o;
  logic [SHARE_W-1:0] rd_share_o;
  logic [BYTE_W-1:0]  rd_byte_o;
  logic               wr_en_o;
  logic [SHARE_W-1:0] wr_share_o;
  logic [BYTE_W-1:0]  wr_byte_o;

  modport master (
    output start_i,
    output hold_i,
    output abort_i,
    input  busy_o,
    input  done_o,
    input  rd_en_o,
    input  rd_share_o,
    input  rd_byte_o,
    input  wr_en_o,
    input  wr_share_o,
    input  wr_byte_o
  );

  modport slave (
    input  start_i,
    input  hold_i,
    input  abort_i,
    output busy_o,
    output done_o,
    output rd_en_o,
    output rd_share_o,
    output rd_byte_o,
    output wr_en_o,
    output wr_share_o,
    output wr_byte_o
  );
endinterface

// File: rtl/ark_share_sequencer.sv
// Share-major read/write sequencer for a byte-serial masked AddRoundKey.
// Reads go out combinationally; the write-back trails by one register stage.
module ark_share_sequencer #(
  parameter int SHARES  = 3,
  parameter int BYTES   = 16,
  parameter int SHARE_W = 2,
  parameter int BYTE_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ark_share_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [SHARE_W-1:0] LAST_SHARE = SHARE_W'(SHARES - 1);
  localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BYTES - 1);

  state_e             state_q, state_d;
  logic [SHARE_W-1:0] sidx_q, sidx_d;
  logic [BYTE_W-1:0]  bidx_q, bidx_d;
  logic               wr_en_q, wr_en_d;
  logic [SHARE_W-1:0] wr_share_q, wr_share_d;
  logic [BYTE_W-1:0]  wr_byte_q, wr_byte_d;
  logic               rd_en;
  logic               done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sidx_q     <= '0;
      bidx_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_share_q <= '0;
      wr_byte_q  <= '0;
    end else begin
      state_q    <= state_d;
      sidx_q     <= sidx_d;
      bidx_q     <= bidx_d;
      wr_en_q    <= wr_en_d;
      wr_share_q <= wr_share_d;
      wr_byte_q  <= wr_byte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sidx_d     = sidx_q;
    bidx_d     = bidx_q;
    wr_en_d    = 1'b0;
    wr_share_d = wr_share_q;
    wr_byte_d  = wr_byte_q;
    rd_en      = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
      end
      RUN: begin
        rd_en = ~bus.hold_i;
        if (bus.abort_i) begin
          // the read may still go out, but its write is dropped
          state_d = IDLE;
          sidx_d  = '0;
          bidx_d  = '0;
        end else if (!bus.hold_i) begin
          wr_en_d    = 1'b1;
          wr_share_d = sidx_q;
          wr_byte_d  = bidx_q;
          if (bidx_q == LAST_BYTE) begin
            bidx_d = '0;
            if (sidx_q == LAST_SHARE) begin
              sidx_d  = '0;
              state_d = DRAIN;
            end else begin
              sidx_d = sidx_q + SHARE_W'(1);
            end
          end else begin
            bidx_d = bidx_q + BYTE_W'(1);
          end
        end
      end
      DRAIN: begin
        done    = ~bus.abort_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sidx_d  = '0;
        bidx_d  = '0;
      end
    endcase
  end

  // counters sit at zero outside RUN, so they double as the read index
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = done;
  assign bus.rd_en_o    = rd_en;
  assign bus.rd_share_o = sidx_q;
  assign bus.rd_byte_o  = bidx_q;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.wr_share_o = wr_share_q;
  assign bus.wr_byte_o  = wr_byte_q;

endmodule
